// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> WRITE_BACK, plus HALT.
// Emits datapath strobes combinationally from the current state and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned   OPW       = 4,
    parameter int unsigned   FLAGW     = 4,
    parameter int unsigned   Z_BIT     = 3,
    parameter int unsigned   CNTW      = 8,
    parameter logic [OPW-1:0] OP_MOV    = OPW'(5),
    parameter logic [OPW-1:0] OP_JMP    = OPW'(6),
    parameter logic [OPW-1:0] OP_JZ     = OPW'(7),
    parameter logic [OPW-1:0] OP_ALU_LO = OPW'(8),
    parameter logic [OPW-1:0] OP_ALU_HI = OPW'(14),
    parameter logic [OPW-1:0] OP_HALT   = OPW'(15)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   opcode,
    input  logic [FLAGW-1:0] status_reg,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             fetch_req,
    output logic             ir_load_en,
    output logic             reg_write_en,
    output logic             alu_en,
    output logic             jump_en,
    output logic             halt,
    output logic [OPW-1:0]   alu_opcode,
    output logic             illegal_op,
    output logic [CNTW-1:0]  retired,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StWriteBack = 3'd3,
        StHalt      = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] retired_q, retired_d;

    logic is_alu, is_mov, is_jmp, is_jz, is_halt, is_legal;

    assign is_alu   = (opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI);
    assign is_mov   = (opcode == OP_MOV);
    assign is_jmp   = (opcode == OP_JMP);
    assign is_jz    = (opcode == OP_JZ);
    assign is_halt  = (opcode == OP_HALT);
    assign is_legal = is_alu || is_mov || is_jmp || is_jz || is_halt;

    always_comb begin
        state_d      = state_q;
        retired_d    = retired_q;
        fetch_req    = 1'b0;
        ir_load_en   = 1'b0;
        reg_write_en = 1'b0;
        alu_en       = 1'b0;
        jump_en      = 1'b0;
        halt         = 1'b0;
        alu_opcode   = '0;
        illegal_op   = 1'b0;

        case (state_q)
            StFetch: begin
                fetch_req  = 1'b1;
                ir_load_en = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                illegal_op = !is_legal;
                state_d    = is_halt ? StHalt : StExecute;
            end
            StExecute: begin
                if (is_alu) begin
                    alu_en     = 1'b1;
                    alu_opcode = opcode;
                    state_d    = StWriteBack;
                end else if (is_jmp || is_jz) begin
                    // Branches retire here and skip WRITE_BACK, taken or not.
                    jump_en   = is_jmp ? 1'b1 : status_reg[Z_BIT];
                    state_d   = StFetch;
                    retired_d = retired_q + CNTW'(1);
                end else begin
                    state_d = StWriteBack;
                end
            end
            StWriteBack: begin
                // Illegal opcodes complete as NOPs: retired, but nothing written.
                reg_write_en = is_alu || is_mov;
                state_d      = StFetch;
                retired_d    = retired_q + CNTW'(1);
            end
            StHalt: begin
                halt = 1'b1;
                if (resume) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model predicts the per-cycle
// state, strobes and retired count for each generated instruction.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [3:0] status_reg;
    logic       mem_ready;
    logic       resume;
    logic       fetch_req, ir_load_en, reg_write_en, alu_en, jump_en, halt, illegal_op;
    logic [3:0] alu_opcode;
    logic [7:0] retired;
    logic [2:0] state_o;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_ret  = '0;

    multicycle_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .status_reg   (status_reg),
        .mem_ready    (mem_ready),
        .resume       (resume),
        .fetch_req    (fetch_req),
        .ir_load_en   (ir_load_en),
        .reg_write_en (reg_write_en),
        .alu_en       (alu_en),
        .jump_en      (jump_en),
        .halt         (halt),
        .alu_opcode   (alu_opcode),
        .illegal_op   (illegal_op),
        .retired      (retired),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] rnd4();
        return 4'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] strobes();
        return {fetch_req, ir_load_en, reg_write_en, alu_en, jump_en, halt, illegal_op};
    endfunction

    // One clock cycle, entered and left at a falling edge; outputs checked 1 time unit after
    // driving, well before the rising edge. Strobe order: fetch,irload,regwr,alu,jump,halt,ill.
    task automatic cyc(input int st, input logic [6:0] stb, input logic [3:0] aop,
                       input logic mr, input logic [3:0] op, input logic [3:0] sr,
                       input logic rs);
        mem_ready  = mr;
        opcode     = op;
        status_reg = sr;
        resume     = rs;
        #1;
        check("state", 32'(state_o), 32'(st));
        check("strobes", 32'(strobes()), 32'(stb));
        check("alu_opcode", 32'(alu_opcode), 32'(aop));
        check("retired", 32'(retired), 32'(exp_ret));
        @(negedge clk);
    endtask

    // Whole-instruction model: stalls in FETCH, then the class-dependent sequence.
    task automatic run_instr(input logic [3:0] op, input int stalls, input logic [3:0] sr,
                             input int hold);
        logic is_alu, legal;
        is_alu = op inside {[8:14]};
        legal  = is_alu || (op inside {5, 6, 7, 15});
        for (int i = 0; i < stalls; i++) cyc(0, 7'b1000000, 4'd0, 1'b0, rnd4(), rnd4(), rnd1());
        cyc(0, 7'b1100000, 4'd0, 1'b1, rnd4(), rnd4(), rnd1());
        cyc(1, {6'b0, !legal}, 4'd0, rnd1(), op, rnd4(), rnd1());
        if (op == 4'd15) begin
            for (int i = 0; i < hold; i++) cyc(4, 7'b0000010, 4'd0, rnd1(), rnd4(), rnd4(), 1'b0);
            cyc(4, 7'b0000010, 4'd0, rnd1(), rnd4(), rnd4(), 1'b1);
        end else if (op == 4'd6) begin
            cyc(2, 7'b0000100, 4'd0, rnd1(), op, rnd4(), rnd1());
            exp_ret++;
        end else if (op == 4'd7) begin
            cyc(2, {4'b0, sr[3], 2'b0}, 4'd0, rnd1(), op, sr, rnd1());
            exp_ret++;
        end else begin
            if (is_alu) cyc(2, 7'b0001000, op, rnd1(), op, rnd4(), rnd1());
            else        cyc(2, 7'b0000000, 4'd0, rnd1(), op, rnd4(), rnd1());
            cyc(3, {2'b0, is_alu || op == 4'd5, 4'b0}, 4'd0, rnd1(), op, rnd4(), rnd1());
            exp_ret++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_ret = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        mem_ready  = 1'b0;
        opcode     = '0;
        status_reg = '0;
        resume     = 1'b0;
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_strobes", 32'(strobes()), 32'b1000000);
        mem_ready = 1'b1;
        #1;
        check("rst_irload", 32'(ir_load_en), 32'd1);
        @(posedge clk);
        #1;
        check("rst_hold_state", 32'(state_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed scenarios.
        run_instr(4'd8, 0, 4'd0, 0);
        run_instr(4'd5, 3, 4'd0, 0);
        run_instr(4'd7, 0, 4'b1000, 0);
        run_instr(4'd7, 0, 4'b0000, 0);
        run_instr(4'd6, 1, 4'd0, 0);
        run_instr(4'd15, 0, 4'd0, 10);
        run_instr(4'd2, 0, 4'd0, 0);
        run_instr(4'd14, 0, 4'd0, 0);

        // Random program.
        for (int n = 0; n < 300; n++)
            run_instr(rnd4(), int'($urandom_range(0, 3)), rnd4(), int'($urandom_range(0, 3)));

        // Bring retired to 255, then reset asynchronously in the middle of EXECUTE.
        do_reset();
        for (int n = 0; n < 255; n++) run_instr(4'd6, 0, 4'd0, 0);
        check("ret_255", 32'(retired), 32'd255);
        cyc(0, 7'b1100000, 4'd0, 1'b1, rnd4(), rnd4(), 1'b0);
        cyc(1, 7'b0000000, 4'd0, 1'b1, 4'd8, rnd4(), 1'b0);
        opcode    = 4'd8;
        mem_ready = 1'b1;
        #1;
        check("pre_rst_exec", 32'(state_o), 32'd2);
        reset = 1'b0;
        #1;
        check("async_state", 32'(state_o), 32'd0);
        check("async_retired", 32'(retired), 32'd0);
        check("async_strobes", 32'(strobes()), 32'b1100000);
        mem_ready = 1'b0;
        #1;
        check("async_irload0", 32'(strobes()), 32'b1000000);
        exp_ret = '0;
        @(negedge clk);
        reset = 1'b1;

        // 256 completions from zero wrap the counter back to zero.
        for (int n = 0; n < 256; n++) run_instr((n % 2) ? 4'd6 : 4'd9, 0, 4'd0, 0);
        check("wrap", 32'(retired), 32'd0);
        run_instr(4'd5, 0, 4'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OPW, default 4, opcode width in bits; SHALL be >= 4.
REQ-002 Parameter FLAGW, default 4, status_reg width.
REQ-003 Parameter Z_BIT, default 3, zero-flag index in status_reg.
REQ-004 Parameter CNTW, default 8, retired-instruction counter width.
REQ-005 Parameters OP_MOV=5, OP_JMP=6, OP_JZ=7, OP_ALU_LO=8, OP_ALU_HI=14, OP_HALT=15 SHALL set the opcode encodings (OPW wide).
REQ-006 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 opcode  input  OPW  current instruction opcode from IR.
REQ-009 status_reg  input  FLAGW  ALU status flags.
REQ-010 mem_ready  input  1  instruction memory data valid.
REQ-011 resume  input  1  leave HALT, return to fetch.
REQ-012 fetch_req  output  1  instruction fetch request.
REQ-013 ir_load_en / reg_write_en / alu_en / jump_en / halt  output  1 each  datapath strobes.
REQ-014 alu_opcode  output  OPW  ALU operation select.
REQ-015 illegal_op  output  1  one-cycle pulse on an unrecognised opcode.
REQ-016 retired  output  CNTW  count of completed instructions.
REQ-017 state_o  output  3  current state code, for debug.

Function
REQ-018 States and codes: FETCH=0, DECODE=1, EXECUTE=2, WRITE_BACK=3, HALT_ST=4; unused codes SHALL go to FETCH on the next edge.
REQ-019 All strobes SHALL be combinational from state, opcode, status_reg, mem_ready and resume; default 0; alu_opcode default 0.
REQ-020 FETCH: fetch_req=1 and ir_load_en=mem_ready; stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-021 DECODE: opcode==OP_HALT goes to HALT_ST; any other opcode goes to EXECUTE.
REQ-022 DECODE: illegal_op=1 for one cycle if opcode is not MOV, JMP, JZ, HALT or in [OP_ALU_LO, OP_ALU_HI].
REQ-023 EXECUTE, ALU range (inclusive): alu_en=1, alu_opcode=opcode; next state WRITE_BACK.
REQ-024 EXECUTE, OP_JMP: jump_en=1; next state FETCH, skipping WRITE_BACK.
REQ-025 EXECUTE, OP_JZ: jump_en=status_reg[Z_BIT]; next state FETCH, whether or not the branch is taken.
REQ-026 EXECUTE, MOV or illegal opcode: no strobes; next state WRITE_BACK.
REQ-027 WRITE_BACK: reg_write_en=1 for MOV and the ALU range; 0 for illegal opcodes, which complete as NOPs; next state FETCH.
REQ-028 retired SHALL increment by 1 on each edge leaving WRITE_BACK and on each edge leaving EXECUTE for JMP/JZ.
REQ-029 retired SHALL wrap modulo 2^CNTW; HALT SHALL not count.
REQ-030 HALT_ST: halt=1; stay while resume=0; go to FETCH on the edge where resume=1.
REQ-031 resume outside HALT_ST SHALL be ignored.
REQ-032 opcode and status_reg are only sampled in the states named above; changes elsewhere SHALL have no effect.
REQ-033 Instruction latency with mem_ready=1: 4 cycles for ALU/MOV/illegal, 3 cycles for JMP/JZ; each mem_ready=0 cycle in FETCH adds 1.

Reset
REQ-034 reset=0 SHALL force state=FETCH and retired=0 immediately, without waiting for a clock edge, including mid-instruction and in HALT_ST.
REQ-035 While reset=0, outputs follow the FETCH decode: fetch_req=1, ir_load_en=mem_ready, all other strobes 0.
REQ-036 The first transition after reset release SHALL occur on the first rising clk edge with reset=1.

Verification
REQ-037 Reset release; mem_ready=1; opcode=8 (ADD) -> states 0,1,2,3,0; alu_en=1 and alu_opcode=8 in EXECUTE; reg_write_en=1 in WRITE_BACK; retired 0->1.
REQ-038 mem_ready held 0 for 3 cycles, then 1 -> 4 cycles in FETCH; ir_load_en=1 only in the 4th; then DECODE.
REQ-039 opcode=7 with status_reg=4'b1000, then status_reg=4'b0000 -> jump_en=1, then 0, in EXECUTE; both return to FETCH after 3 cycles; retired +1 each.
REQ-040 opcode=15 -> halt=1 held for 10 cycles with resume=0; resume=1 -> FETCH next edge; retired unchanged.
REQ-041 opcode=2 (illegal) -> illegal_op pulses in DECODE; no alu_en or reg_write_en; retired +1.
REQ-042 reset=0 asserted mid-EXECUTE with retired=255 (CNTW=8) -> state_o=0 and retired=0 before the next edge; separately, 256 completions from 0 -> retired wraps to 0.
